// File: rtl/dr_inject_if.sv
// Requester, dual-rail stage and status signals of the dual-rail injector.
// slave = arbiter side, master = requesters plus asynchronous stage.
interface dr_inject_if #(
    parameter int N_BITS = 4
);
    logic                  req0;
    logic [N_BITS-1:0]     data0;
    logic                  gnt0;
    logic                  req1;
    logic [N_BITS-1:0]     data1;
    logic                  gnt1;
    logic [2*N_BITS-1:0]   dr_data;
    logic                  dr_ack;
    logic                  busy;
    logic                  last_id;
    logic                  timeout_err;

    modport slave (
        input  req0, data0, req1, data1, dr_ack,
        output gnt0, gnt1, dr_data, busy, last_id, timeout_err
    );

    modport master (
        output req0, data0, req1, data1, dr_ack,
        input  gnt0, gnt1, dr_data, busy, last_id, timeout_err
    );
endinterface

// File: rtl/dr_inject_arbiter.sv
// Round-robin injector of two clocked requesters into one async dual-rail RTZ stage.
// Codeword appears on the grant edge; spacer follows SYNC_STAGES+1 edges after ack rises.
module dr_inject_arbiter #(
    parameter int N_BITS      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic         clk,
    input  logic         rst,
    dr_inject_if.slave   bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, DATA, SPACER, ERR} state_t;

    state_t                state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [2*N_BITS-1:0]   dr_q, dr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  rr_q, rr_d;
    logic                  last_q, last_d;
    logic                  err_q, err_d;
    logic                  ack_s;
    logic                  win_id;
    logic                  grant;

    function automatic logic [2*N_BITS-1:0] encode(input logic [N_BITS-1:0] d);
        logic [2*N_BITS-1:0] e;
        e = '0;
        for (int i = 0; i < N_BITS; i++) begin
            e[2*i+1] = d[i];
            e[2*i]   = ~d[i];
        end
        return e;
    endfunction

    assign ack_s  = sync_q[SYNC_STAGES-1];
    assign win_id = (bus.req0 & bus.req1) ? rr_q : bus.req1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= IDLE;
            dr_q    <= '0;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.dr_ack};
            state_q <= state_d;
            dr_q    <= dr_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dr_d    = dr_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        last_d  = last_q;
        err_d   = err_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                // ack still high means the stage has not returned to zero yet
                if (!ack_s && (bus.req0 || bus.req1)) begin
                    grant   = 1'b1;
                    dr_d    = encode(win_id ? bus.data1 : bus.data0);
                    last_d  = win_id;
                    rr_d    = ~win_id;
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA, SPACER: begin
                if ((state_q == DATA) ? ack_s : !ack_s) begin
                    cnt_d   = '0;
                    dr_d    = '0;
                    state_d = (state_q == DATA) ? SPACER : IDLE;
                end else if (TIMEOUT != 0) begin
                    if (cnt_q == TMO_LAST) begin
                        dr_d    = '0;
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // grant pulses are masked during reset so nothing is accepted while state is forced
    assign bus.gnt0        = grant & ~win_id & ~rst;
    assign bus.gnt1        = grant &  win_id & ~rst;
    assign bus.dr_data     = dr_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.last_id     = last_q;
    assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_dr_inject_arbiter.sv
// Scoreboard bench: tests push expected grants, a negedge monitor pops and compares.
module tb_dr_inject_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    dr_inject_if #(.N_BITS(4)) ifa ();
    dr_inject_if #(.N_BITS(4)) ifb ();

    dr_inject_arbiter #(.N_BITS(4), .SYNC_STAGES(2), .TIMEOUT(0)) dut_a (
        .clk(clk), .rst(rst_a), .bus(ifa));
    dr_inject_arbiter #(.N_BITS(4), .SYNC_STAGES(2), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst_b), .bus(ifb));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { logic id; logic [7:0] code; } exp_t;
    exp_t sb_q[$];
    exp_t pend_e;
    bit   pend = 1'b0;

    bit auto_a  = 1'b1;
    bit ack_man = 1'b0;
    int dly_a   = 3;
    int ack_rise = 0;
    int ack_fall = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Stage model: ack follows data/spacer after dly_a cycles, or tracks ack_man
    initial begin
        int c;
        c = 0;
        ifa.dr_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!auto_a) begin
                ifa.dr_ack = ack_man;
                c = 0;
            end else if ((ifa.dr_data != 8'h00) != ifa.dr_ack) begin
                c++;
                if (c >= dly_a) begin
                    ifa.dr_ack = ~ifa.dr_ack;
                    c = 0;
                    if (ifa.dr_ack) ack_rise = cyc;
                    else            ack_fall = cyc;
                end
            end else begin
                c = 0;
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_a) begin
                bit bad;
                logic [7:0] d;
                d = ifa.dr_data;
                bad = 1'b0;
                for (int i = 0; i < 4; i++) if (d[2*i +: 2] == 2'b11) bad = 1'b1;
                chk1("pair_never_11", bad, 1'b0);
                if (pend) begin
                    chk8("codeword", ifa.dr_data, pend_e.code);
                    chk1("last_id", ifa.last_id, pend_e.id);
                    pend = 1'b0;
                end
                if (ifa.gnt0 || ifa.gnt1) begin
                    chk1("gnt_exclusive", ifa.gnt0 & ifa.gnt1, 1'b0);
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_grant actual=gnt1:%0b required=no grant", ifa.gnt1);
                    end else begin
                        pend_e = sb_q.pop_front();
                        chk1("grant_id", ifa.gnt1, pend_e.id);
                        pend = 1'b1;
                    end
                end
            end
        end
    end

    task automatic send(input bit id, input logic [3:0] d);
        bit g;
        int n;
        if (id) begin ifa.req1 = 1'b1; ifa.data1 = d; end
        else    begin ifa.req0 = 1'b1; ifa.data0 = d; end
        n = 0;
        g = 1'b0;
        while (!g && n < 200) begin
            @(negedge clk);
            g = id ? ifa.gnt1 : ifa.gnt0;
            @(posedge clk);
            #1;
            n++;
        end
        if (!g) begin
            checks++;
            errors++;
            $display("FAIL grant_wait id=%0d actual=no grant required=grant", id);
        end
        if (id) ifa.req1 = 1'b0;
        else    ifa.req0 = 1'b0;
    endtask

    task automatic reset_a();
        chkn("sb_drained", sb_q.size(), 0);
        ifa.req0 = 1'b0;
        ifa.req1 = 1'b0;
        rst_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk8("rst_dr_data", ifa.dr_data, 8'h00);
        chk1("rst_busy", ifa.busy, 1'b0);
        chk1("rst_gnt0", ifa.gnt0, 1'b0);
        chk1("rst_gnt1", ifa.gnt1, 1'b0);
        chk1("rst_last_id", ifa.last_id, 1'b0);
        chk1("rst_timeout_err", ifa.timeout_err, 1'b0);
        @(posedge clk);
        #1 rst_a = 1'b0;
        if (auto_a) begin
            for (int n = 0; n < 100 && ifa.dr_ack; n++) @(negedge clk);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle_a(input string name, input int lim);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ifa.busy && n < lim);
        chk1(name, ifa.busy, 1'b0);
    endtask

    initial begin
        int n;
        int seen;
        int gc;
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.req0 = 1'b0; ifa.req1 = 1'b0; ifa.data0 = 4'h0; ifa.data1 = 4'h0;
        ifb.req0 = 1'b0; ifb.req1 = 1'b0; ifb.data0 = 4'h0; ifb.data1 = 4'h0;
        ifb.dr_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // 1: single word, latencies from ack edges
        reset_a();
        sb_q.push_back('{id: 1'b0, code: 8'b10011001});
        send(1'b0, 4'hA);
        n = 0;
        do begin @(negedge clk); n++; end while (ifa.dr_data != 8'h00 && n < 50);
        chk8("t1_spacer", ifa.dr_data, 8'h00);
        chkn("t1_spacer_latency", cyc - ack_rise, 3);
        wait_idle_a("t1_idle", 50);
        chkn("t1_idle_latency", cyc - ack_fall, 3);
        chk1("t1_last_id", ifa.last_id, 1'b0);

        // 2: both held, alternating grants from reset pointer
        reset_a();
        sb_q.push_back('{id: 1'b0, code: 8'b01010110});
        sb_q.push_back('{id: 1'b1, code: 8'b10101010});
        sb_q.push_back('{id: 1'b0, code: 8'b01010110});
        sb_q.push_back('{id: 1'b1, code: 8'b10101010});
        fork
            begin send(1'b0, 4'h1); send(1'b0, 4'h1); end
            begin send(1'b1, 4'hF); send(1'b1, 4'hF); end
        join
        wait_idle_a("t2_idle", 100);
        chk1("t2_last_id", ifa.last_id, 1'b1);

        // 3: ack held high blocks grants until it falls
        auto_a = 1'b0;
        ack_man = 1'b1;
        repeat (2) @(negedge clk);
        reset_a();
        sb_q.push_back('{id: 1'b1, code: 8'b01100110});
        ifa.req1 = 1'b1;
        ifa.data1 = 4'h5;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (ifa.gnt1 || ifa.gnt0) seen++;
        end
        chkn("t3_no_grant_while_ack", seen, 0);
        ack_man = 1'b0;
        send(1'b1, 4'h5);
        auto_a = 1'b1;
        wait_idle_a("t3_idle", 100);

        // 5: reset mid-handshake, pointer back to requester 0
        reset_a();
        auto_a = 1'b0;
        ack_man = 1'b0;
        sb_q.push_back('{id: 1'b0, code: 8'b10011001});
        send(1'b0, 4'hA);
        repeat (2) @(negedge clk);
        chk1("t5_busy_in_data", ifa.busy, 1'b1);
        reset_a();
        auto_a = 1'b1;
        sb_q.push_back('{id: 1'b0, code: 8'b10011001});
        sb_q.push_back('{id: 1'b1, code: 8'b10101010});
        fork
            send(1'b0, 4'hA);
            send(1'b1, 4'hF);
        join
        wait_idle_a("t5_idle", 100);

        // 6: TIMEOUT=0 with a very slow stage
        reset_a();
        dly_a = 1000;
        sb_q.push_back('{id: 1'b0, code: 8'b01101001});
        send(1'b0, 4'h6);
        wait_idle_a("t6_idle", 2300);
        chk1("t6_no_timeout", ifa.timeout_err, 1'b0);
        dly_a = 3;
        reset_a();

        // 4: TIMEOUT=8 instance, stage never acks
        @(negedge clk);
        chk1("t4_rst_timeout_err", ifb.timeout_err, 1'b0);
        chk1("t4_rst_busy", ifb.busy, 1'b0);
        @(posedge clk);
        #1 rst_b = 1'b0;
        ifb.req0 = 1'b1;
        ifb.data0 = 4'h3;
        n = 0;
        do begin @(negedge clk); n++; end while (!ifb.gnt0 && n < 20);
        chk1("t4_gnt0", ifb.gnt0, 1'b1);
        gc = cyc + 1;
        @(posedge clk);
        #1 ifb.req0 = 1'b0;
        @(negedge clk);
        chk8("t4_codeword", ifb.dr_data, 8'b01011010);
        chk1("t4_err_early", ifb.timeout_err, 1'b0);
        n = 0;
        while (!ifb.timeout_err && n < 50) begin @(negedge clk); n++; end
        chk1("t4_timeout_err", ifb.timeout_err, 1'b1);
        chkn("t4_timeout_cycles", cyc - gc, 8);
        chk8("t4_dr_data_zero", ifb.dr_data, 8'h00);
        chk1("t4_busy", ifb.busy, 1'b1);
        ifb.req1 = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (ifb.gnt0 || ifb.gnt1) seen++;
        end
        chkn("t4_no_grant_in_err", seen, 0);
        ifb.req1 = 1'b0;
        chk1("t4_err_sticky", ifb.timeout_err, 1'b1);
        rst_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk1("t4_rst_clears_err", ifb.timeout_err, 1'b0);
        chk1("t4_rst_busy_after", ifb.busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
